muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit, parametrised by XLEN. It is the multi-cycle companion to the combinational ALU control/ALU path. It accepts an M-extension op (funct3 decode, funct7=0000001 already qualified upstream) with a start/done handshake, and computes the result over XLEN+2 cycles. Divide-by-zero and signed overflow take a 1-cycle fast path. Sits beside the ALU in the execute stage; the core stalls while busy=1.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                neg_q;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN:0]       rem;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     res_stage, res_hold;

  function automatic logic [XLEN-1:0] neg_narrow(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode at acceptance
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, neg_res;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;

  always_comb begin
    is_div   = funct3[2];
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = sgn_a & op_a[XLEN-1];
    b_neg    = sgn_b & op_b[XLEN-1];
    a_abs    = neg_narrow(op_a, a_neg);
    b_abs    = neg_narrow(op_b, b_neg);
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_res  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = funct3[1] ? op_a : '1;
    else          fast_res = funct3[1] ? '0 : op_a;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_nxt;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? a_mag : {XLEN{1'b0}})};
    prod_nxt  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {rem[XLEN-1:0], quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_ge    = ~div_diff[XLEN];
  end

  // Sign correction and half/quotient/remainder selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_wide(prod, neg_q);
    case (op_q)
      3'b000:         fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = neg_narrow(quo, neg_q);
      default:        fix_res = neg_narrow(rem[XLEN-1:0], neg_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_q      <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      neg_q     <= 1'b0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      res_stage <= '0;
      res_hold  <= '0;
    end else begin
      case (state)
        IDLE: if (start && !kill) begin
          op_q  <= funct3;
          a_mag <= a_abs;
          b_mag <= b_abs;
          neg_q <= neg_res;
          cnt   <= CNT_W'(XLEN);
          prod  <= {{XLEN{1'b0}}, b_abs};
          rem   <= '0;
          quo   <= a_abs;
          if (fast) res_stage <= fast_res;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (op_q[2]) begin
            rem <= div_ge ? div_diff : div_shift;
            quo <= {quo[XLEN-2:0], div_ge};
          end else begin
            prod <= prod_nxt;
          end
        end
        FIX:  res_stage <= fix_res;
        DONE: if (!kill) res_hold <= res_stage;
        default: ;
      endcase
    end
  end

  // The staged result is shown only during an unkilled done cycle
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE) && !kill;
    result = done ? res_stage : res_hold;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one op; operands are scrambled after acceptance, and a stray start
  // can be injected at cycle inj (0 = none).
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int inj);
    int lat;
    logic bad_busy;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; op_a = ~a; op_b = 32'h3; lat = 1; bad_busy = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) bad_busy = 1'b1;
      start = (lat == inj);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!busy) bad_busy = 1'b1;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, result, exp);
    chk({tag, " busy"}, bad_busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, " single done"}, {done, busy}, 2'b00);
    chk({tag, " result held"}, result, exp);
  endtask

  initial begin
    int lat;
    logic saw_done;

    #1;
    chk("reset outputs", {busy, done, result}, 34'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("MUL 7x-3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op("MULH",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op("MULHU",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op("MULHSU",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
    run_op("DIV -7/2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    run_op("REM -7/2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("DIVU 100/7", 3'b101, 32'd100,      32'd7,        32'd14,       34, 0);
    run_op("REMU 100/7", 3'b111, 32'd100,      32'd7,        32'd2,        34, 0);
    run_op("DIV ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("REM ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
    run_op("DIVU 5/0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("REMU 5/0",   3'b111, 32'd5,        32'd0,        32'd5,        1, 0);
    run_op("MUL stray start", 3'b000, 32'd7,   32'hFFFFFFFD, 32'hFFFFFFEB, 34, 5);

    // A start held through the done cycle must not launch a new op
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    chk("start-in-done done", done, 1'b1);
    chk("start-in-done result", result, 32'hFFFFFFFF);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start-in-done ignored", {busy, done}, 2'b00);
    run_op("REMU 5/0 again", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0);

    // Kill a divide at cycle 10
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("kill pre busy", busy, 1'b1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill busy/done", {busy, done}, 2'b00);
    chk("kill result kept", result, 32'd5);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("kill no done", saw_done, 1'b0);
    run_op("MUL 3x4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {busy, done, result}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("reset discards op", saw_done, 1'b0);

    // Back-to-back after reset
    run_op("b2b MULHU",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 34, 0);
    run_op("b2b DIV",    3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0);
    run_op("b2b REM",    3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        34, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
